// File: rtl/mem_req_master_if.sv
// Bus bundle for mem_req_master: CPU-side request/response channels plus the
// byte-addressed synchronous memory port.
//
// Handshake rule for both channels: a beat transfers on a rising clock edge
// where valid and ready are both high. A source that raises valid keeps valid
// and its payload stable until that edge; ready may change freely and carries
// no meaning while valid is low.
interface mem_req_master_if;
  // CPU request channel
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_sz;     // 0 = 8-bit, 1 = 16-bit
  logic        req_we;     // 1 = store, 0 = load

  // CPU response channel
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_rdata;

  // Memory port
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_sz;
  logic        mem_we;
  logic [15:0] mem_rdata;

  modport master (
    input  req_valid, req_addr, req_wdata, req_sz, req_we,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata,
    output mem_addr, mem_wdata, mem_sz, mem_we
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_sz, req_we,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  mem_addr, mem_wdata, mem_sz, mem_we
  );
endinterface

// File: rtl/mem_req_master.sv
// mem_req_master: initiator for the byte-addressed synchronous memory bus.
// Takes one load/store at a time from the CPU, drives the memory port for a
// single issue cycle, waits RD_LAT cycles for load data and holds the result
// on the response channel until it is accepted.
//
// Optional build macro MEM_MASTER_SPLIT16_EN: every 16-bit request is done as
// two 8-bit accesses (high byte at addr, low byte at addr+1 with 16-bit wrap),
// so mem_sz is always 0. Without the macro a 16-bit request is one mem_sz=1
// access.
//
// state_o exposes the FSM state for debug/checkers.
module mem_req_master #(
  parameter int RD_LAT = 1  // issue edge to read data valid, 1..3
) (
  input  logic             clk,
  input  logic             reset,    // asynchronous, active-low
  mem_req_master_if.master bus,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    RESP   = 3'd3
`ifdef MEM_MASTER_SPLIT16_EN
    , ISSUE2 = 3'd4,
    WAIT2  = 3'd5
`endif
  } state_t;

  // Counter reload so that the capture happens RD_LAT cycles after issue.
  localparam logic [1:0] LatM1 = 2'(RD_LAT - 1);

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic        sz_q;          // size of the request in flight
  logic        we_q;          // type of the request in flight
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [15:0] resp_rdata_q;
  logic [15:0] mem_addr_q;
  logic [15:0] mem_wdata_q;
  logic        mem_sz_q;
  logic        mem_we_q;
`ifdef MEM_MASTER_SPLIT16_EN
  logic [15:0] wdata_q;       // keeps the low store byte for the second access
`endif

  // Request FSM: all outputs are registered and move together with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      sz_q         <= 1'b0;
      we_q         <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 16'h0000;
      mem_addr_q   <= 16'h0000;
      mem_wdata_q  <= 16'h0000;
      mem_sz_q     <= 1'b0;
      mem_we_q     <= 1'b0;
`ifdef MEM_MASTER_SPLIT16_EN
      wdata_q      <= 16'h0000;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            sz_q        <= bus.req_sz;
            we_q        <= bus.req_we;
            mem_addr_q  <= bus.req_addr;
            mem_we_q    <= bus.req_we;
            req_ready_q <= 1'b0;
`ifdef MEM_MASTER_SPLIT16_EN
            wdata_q     <= bus.req_wdata;
            mem_sz_q    <= 1'b0;
            // A split 16-bit store writes the high byte first.
            mem_wdata_q <= bus.req_sz ? {8'h00, bus.req_wdata[15:8]} : bus.req_wdata;
`else
            mem_sz_q    <= bus.req_sz;
            mem_wdata_q <= bus.req_wdata;
`endif
            state_q     <= ISSUE;
          end
        end

        ISSUE: begin
          mem_we_q <= 1'b0;
          if (we_q) begin
`ifdef MEM_MASTER_SPLIT16_EN
            if (sz_q) begin
              mem_addr_q  <= mem_addr_q + 16'd1;
              mem_wdata_q <= {8'h00, wdata_q[7:0]};
              mem_we_q    <= 1'b1;
              state_q     <= ISSUE2;
            end else
`endif
            begin
              resp_rdata_q <= 16'h0000;
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end
          end else begin
            cnt_q   <= LatM1;
            state_q <= WAIT;
          end
        end

        WAIT: begin
          if (cnt_q == 2'd0) begin
`ifdef MEM_MASTER_SPLIT16_EN
            if (sz_q) begin
              // High byte comes from the first access; the low byte follows.
              resp_rdata_q <= {bus.mem_rdata[7:0], 8'h00};
              mem_addr_q   <= mem_addr_q + 16'd1;
              state_q      <= ISSUE2;
            end else
`endif
            begin
              resp_rdata_q <= sz_q ? bus.mem_rdata : {8'h00, bus.mem_rdata[7:0]};
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end

`ifdef MEM_MASTER_SPLIT16_EN
        ISSUE2: begin
          mem_we_q <= 1'b0;
          if (we_q) begin
            resp_rdata_q <= 16'h0000;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            cnt_q   <= LatM1;
            state_q <= WAIT2;
          end
        end

        WAIT2: begin
          if (cnt_q == 2'd0) begin
            resp_rdata_q[7:0] <= bus.mem_rdata[7:0];
            resp_valid_q      <= 1'b1;
            state_q           <= RESP;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
`endif

        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end

        default: begin
          mem_we_q     <= 1'b0;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_sz     = mem_sz_q;
  assign bus.mem_we     = mem_we_q;
  assign state_o        = state_q;

endmodule
